// File: rtl/omr_pkg.sv
// omr_pkg: shared types and width helpers for the OMR sheet scorer.
// The FSM state enum, the per-question answer class and the width
// functions live here so that the interface, the classifier and the top
// all size their signals identically.
package omr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } omr_state_e;

    typedef enum logic [1:0] {
        BLANK   = 2'd0,
        CORRECT = 2'd1,
        WRONG   = 2'd2,
        INVALID = 2'd3
    } omr_class_e;

    // Width of one per-class counter: it must hold the value nq.
    function automatic int omr_cw(input int nq);
        return $clog2(nq + 1);
    endfunction

    // Width of the signed score: counter width, plus room for the point
    // multiplier, plus a sign bit.
    function automatic int omr_sw(input int nq, input int pos_pts, input int neg_pts);
        return omr_cw(nq) + $clog2(pos_pts + neg_pts + 1) + 1;
    endfunction

    // Width of the question index. It is never allowed to be zero.
    function automatic int omr_qw(input int nq);
        return (nq > 1) ? $clog2(nq) : 1;
    endfunction

endpackage

// File: rtl/omr_scorer_if.sv
// omr_scorer_if: groups the request and the result signals of the scorer.
// The master drives start, key_in and resp_in. The slave returns the
// status and the graded counts.
interface omr_scorer_if #(
    parameter int NQ      = 10,
    parameter int NOPT    = 4,
    parameter int POS_PTS = 1,
    parameter int NEG_PTS = 1
);
    import omr_pkg::*;

    localparam int CW = omr_cw(NQ);
    localparam int SW = omr_sw(NQ, POS_PTS, NEG_PTS);

    logic                 start;
    logic [NQ*NOPT-1:0]   key_in;
    logic [NQ*NOPT-1:0]   resp_in;
    logic                 busy;
    logic                 done;
    logic [CW-1:0]        correct_cnt;
    logic [CW-1:0]        wrong_cnt;
    logic [CW-1:0]        blank_cnt;
    logic [CW-1:0]        invalid_cnt;
    logic signed [SW-1:0] score;
    logic                 key_err;

    modport master (
        output start, key_in, resp_in,
        input  busy, done, correct_cnt, wrong_cnt, blank_cnt, invalid_cnt,
               score, key_err
    );

    modport slave (
        input  start, key_in, resp_in,
        output busy, done, correct_cnt, wrong_cnt, blank_cnt, invalid_cnt,
               score, key_err
    );

endinterface

// File: rtl/omr_q_classify.sv
// omr_q_classify: purely combinational grading of a single question.
// The response is checked first. A blank or multi-marked response is
// classed as BLANK or INVALID whatever the key holds. A single mark is
// CORRECT only when the key is one-hot and equal to it.
module omr_q_classify
    import omr_pkg::*;
#(
    parameter int NOPT = 4
) (
    input  logic [NOPT-1:0] key,
    input  logic [NOPT-1:0] resp,
    output omr_class_e      cls,
    output logic            key_bad
);

    logic key_onehot;
    logic resp_multi;

    // Perform the one-hot tests (x & (x-1) clears the lowest set bit) and select the class.
    always_comb begin
        key_onehot = (key != '0) && ((key & (key - NOPT'(1))) == '0);
        resp_multi = ((resp & (resp - NOPT'(1))) != '0);
        key_bad    = !key_onehot;
        cls        = BLANK;
        if (resp == '0) begin
            cls = BLANK;
        end else if (resp_multi) begin
            cls = INVALID;
        end else if (key_onehot && (resp == key)) begin
            cls = CORRECT;
        end else begin
            cls = WRONG;
        end
    end

endmodule

// File: rtl/omr_scorer.sv
// omr_scorer: grades one OMR sheet per start request, one question per cycle.
// The key and the response are snapshotted when start is accepted. The scan
// then walks questions 0..NQ-1. The score is produced on the DONE cycle and
// is held with the counters until the next start is accepted.
// Optional feature: define OMR_NEG_MARK_EN to deduct NEG_PTS for each wrong
// or invalid answer. Without it the score is POS_PTS * correct_cnt.
module omr_scorer
    import omr_pkg::*;
#(
    parameter int NQ      = 10,
    parameter int NOPT    = 4,
    parameter int POS_PTS = 1,
    parameter int NEG_PTS = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    omr_scorer_if.slave  bus
);

    localparam int CW = omr_cw(NQ);
    localparam int SW = omr_sw(NQ, POS_PTS, NEG_PTS);
    localparam int QW = omr_qw(NQ);
    localparam int NB = NQ * NOPT;

    omr_state_e           state_q,   state_d;
    logic [QW-1:0]        idx_q,     idx_d;
    logic [NB-1:0]        key_q,     key_d;
    logic [NB-1:0]        resp_q,    resp_d;
    logic [CW-1:0]        correct_q, correct_d;
    logic [CW-1:0]        wrong_q,   wrong_d;
    logic [CW-1:0]        blank_q,   blank_d;
    logic [CW-1:0]        invalid_q, invalid_d;
    logic signed [SW-1:0] score_q,   score_d;
    logic                 key_err_q, key_err_d;

    // Split the latched sheet into per-question slots so the scan can index them.
    logic [NOPT-1:0] key_slot  [NQ];
    logic [NOPT-1:0] resp_slot [NQ];

    for (genvar gi = 0; gi < NQ; gi++) begin : g_slot
        assign key_slot[gi]  = key_q[gi*NOPT +: NOPT];
        assign resp_slot[gi] = resp_q[gi*NOPT +: NOPT];
    end

    logic [NOPT-1:0] cur_key;
    logic [NOPT-1:0] cur_resp;
    omr_class_e      cur_cls;
    logic            cur_key_bad;

    assign cur_key  = key_slot[idx_q];
    assign cur_resp = resp_slot[idx_q];

    omr_q_classify #(
        .NOPT (NOPT)
    ) u_classify (
        .key     (cur_key),
        .resp    (cur_resp),
        .cls     (cur_cls),
        .key_bad (cur_key_bad)
    );

    // Compute the next state: accept start in IDLE, tally one question per SCAN cycle, then finish.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        key_d     = key_q;
        resp_d    = resp_q;
        correct_d = correct_q;
        wrong_d   = wrong_q;
        blank_d   = blank_q;
        invalid_d = invalid_q;
        score_d   = score_q;
        key_err_d = key_err_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = SCAN;
                    idx_d     = '0;
                    key_d     = bus.key_in;
                    resp_d    = bus.resp_in;
                    correct_d = '0;
                    wrong_d   = '0;
                    blank_d   = '0;
                    invalid_d = '0;
                    score_d   = '0;
                    key_err_d = 1'b0;
                end
            end
            SCAN: begin
                case (cur_cls)
                    CORRECT: correct_d = correct_q + CW'(1);
                    WRONG:   wrong_d   = wrong_q   + CW'(1);
                    INVALID: invalid_d = invalid_q + CW'(1);
                    default: blank_d   = blank_q   + CW'(1);
                endcase
                key_err_d = key_err_q | cur_key_bad;
                if (idx_q == QW'(NQ - 1)) begin
                    // The score is formed from the final tallies, so it is valid on the DONE cycle.
                    state_d = DONE;
`ifdef OMR_NEG_MARK_EN
                    score_d = SW'(POS_PTS) * SW'(correct_d)
                            - SW'(NEG_PTS) * (SW'(wrong_d) + SW'(invalid_d));
`else
                    score_d = SW'(POS_PTS) * SW'(correct_d);
`endif
                end else begin
                    idx_d = idx_q + QW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers. Reset is asynchronous, so a scan in progress is dropped without a done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            key_q     <= '0;
            resp_q    <= '0;
            correct_q <= '0;
            wrong_q   <= '0;
            blank_q   <= '0;
            invalid_q <= '0;
            score_q   <= '0;
            key_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            key_q     <= key_d;
            resp_q    <= resp_d;
            correct_q <= correct_d;
            wrong_q   <= wrong_d;
            blank_q   <= blank_d;
            invalid_q <= invalid_d;
            score_q   <= score_d;
            key_err_q <= key_err_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.correct_cnt = correct_q;
    assign bus.wrong_cnt   = wrong_q;
    assign bus.blank_cnt   = blank_q;
    assign bus.invalid_cnt = invalid_q;
    assign bus.score       = score_q;
    assign bus.key_err     = key_err_q;

endmodule

// File: tb/tb_omr_scorer.sv
// tb_omr_scorer: table-driven check of omr_scorer (NQ=10, NOPT=4, 1/1 points)
// plus hand-written sequences for reset behaviour and for the multi-cycle cases.
module tb_omr_scorer;

    localparam int NQ      = 10;
    localparam int NOPT    = 4;
    localparam int POS_PTS = 1;
    localparam int NEG_PTS = 1;
    localparam int NB      = NQ * NOPT;

    localparam logic [NB-1:0] KEY = 40'h12_2412_1888;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    omr_scorer_if #(.NQ(NQ), .NOPT(NOPT), .POS_PTS(POS_PTS), .NEG_PTS(NEG_PTS)) bus ();

    omr_scorer #(.NQ(NQ), .NOPT(NOPT), .POS_PTS(POS_PTS), .NEG_PTS(NEG_PTS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // mode: 0 = plain, 1 = start pulsed again in cycles 3..8, 2 = inputs changed during the scan
    typedef struct {
        logic [NB-1:0] key;
        logic [NB-1:0] resp;
        int c, w, b, i;
        int sc_pos;
        int sc_neg;
        int kerr;
        int mode;
    } vec_t;

    vec_t vecs [8];
    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"},    int'(bus.busy), 0);
        check({tag, " done"},    int'(bus.done), 0);
        check({tag, " correct"}, int'(bus.correct_cnt), 0);
        check({tag, " wrong"},   int'(bus.wrong_cnt), 0);
        check({tag, " blank"},   int'(bus.blank_cnt), 0);
        check({tag, " invalid"}, int'(bus.invalid_cnt), 0);
        check({tag, " score"},   int'(bus.score), 0);
        check({tag, " key_err"}, int'(bus.key_err), 0);
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic run_vec(input int id, input vec_t v);
        int cyc;
        int busy_cnt;
        int done_cnt;
        int exp_sc;
        int held_c;
`ifdef OMR_NEG_MARK_EN
        exp_sc = v.sc_neg;
`else
        exp_sc = v.sc_pos;
`endif
        bus.start   = 1'b1;
        bus.key_in  = v.key;
        bus.resp_in = v.resp;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (v.mode == 2) begin
            bus.key_in  = ~v.key;
            bus.resp_in = '0;
        end
        cyc = 1;
        busy_cnt = 0;
        done_cnt = 0;
        while (cyc <= 30 && done_cnt == 0) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                check($sformatf("v%0d done_cycle", id), cyc, NQ + 1);
                check($sformatf("v%0d correct", id), int'(bus.correct_cnt), v.c);
                check($sformatf("v%0d wrong", id),   int'(bus.wrong_cnt), v.w);
                check($sformatf("v%0d blank", id),   int'(bus.blank_cnt), v.b);
                check($sformatf("v%0d invalid", id), int'(bus.invalid_cnt), v.i);
                check($sformatf("v%0d score", id),   int'(bus.score), exp_sc);
                check($sformatf("v%0d key_err", id), int'(bus.key_err), v.kerr);
            end else begin
                if (v.mode == 1) bus.start = (cyc >= 2 && cyc <= 7);
                @(posedge clk); #1;
                cyc++;
            end
        end
        bus.start = 1'b0;
        check($sformatf("v%0d done_seen", id), done_cnt, 1);
        check($sformatf("v%0d busy_cycles", id), busy_cnt, NQ + 1);
        held_c = int'(bus.correct_cnt);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (bus.done) done_cnt++;
            check($sformatf("v%0d idle_busy%0d", id, k), int'(bus.busy), 0);
        end
        check($sformatf("v%0d done_pulses", id), done_cnt, 1);
        check($sformatf("v%0d correct_held", id), int'(bus.correct_cnt), held_c);
        check($sformatf("v%0d score_held", id), int'(bus.score), exp_sc);
        $display("vec %0d: key=%h resp=%h correct=%0d wrong=%0d blank=%0d invalid=%0d score=%0d key_err=%0d",
                 id, v.key, v.resp, bus.correct_cnt, bus.wrong_cnt, bus.blank_cnt,
                 bus.invalid_cnt, bus.score, bus.key_err);
    endtask

    initial begin
        int dones;
        //          key             resp             c  w  b  i  pos neg kerr mode
        vecs[0] = '{KEY,            KEY,             10, 0, 0, 0, 10, 10, 0, 0};
        vecs[1] = '{KEY,            40'h1224123014,   6, 2, 1, 1,  6,  3, 0, 0};
        vecs[2] = '{40'h1224021888, KEY,              9, 1, 0, 0,  9,  8, 1, 0};
        vecs[3] = '{KEY,            KEY,             10, 0, 0, 0, 10, 10, 0, 1};
        vecs[4] = '{KEY,            40'h0,            0, 0, 10, 0, 0,  0, 0, 0};
        vecs[5] = '{KEY,            40'hFFFFFFFFFF,   0, 0, 0, 10, 0, -10, 0, 0};
        vecs[6] = '{KEY,            40'h2111212111,   0, 10, 0, 0, 0, -10, 0, 0};
        vecs[7] = '{40'h1224121883, 40'h1224121883,   9, 0, 0, 1,  9,  8, 1, 2};

        bus.start   = 1'b0;
        bus.key_in  = '0;
        bus.resp_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int n = 0; n < 8; n++) begin
            run_vec(n, vecs[n]);
        end

        // Reset in the middle of a scan: outputs clear at once and the abandoned scan never reports done.
        bus.start   = 1'b1;
        bus.key_in  = vecs[7].key;
        bus.resp_in = vecs[7].resp;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clk); #1;
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) dones++;
        end
        check("midreset no_done", dones, 0);
        $display("midreset: busy/done cycles after release=%0d", dones);

        run_vec(8, vecs[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/omr_scorer.md
OMR_SCORER -- requirements
Module: omr_scorer

Interface
REQ-001 SHALL have parameter NQ, default 10: number of questions per sheet (range 1..255).
REQ-002 SHALL have parameter NOPT, default 4: options per question, one bit per option (range 2..8).
REQ-003 SHALL have parameter POS_PTS, default 1: points added per correct answer.
REQ-004 SHALL have parameter NEG_PTS, default 1: points deducted per wrong or invalid answer (used only with OMR_NEG_MARK_EN).
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1: request to grade the presented sheets.
REQ-008 SHALL have port key_in, input, NQ*NOPT: answer key; question q occupies bits [q*NOPT +: NOPT].
REQ-009 SHALL have port resp_in, input, NQ*NOPT: student marks, same packing as key_in.
REQ-010 SHALL have port busy, output, 1: grading in progress.
REQ-011 SHALL have port done, output, 1: one-cycle pulse, results valid.
REQ-012 SHALL have ports correct_cnt, wrong_cnt, blank_cnt, invalid_cnt, output, CW=$clog2(NQ+1) each: per-class question counts.
REQ-013 SHALL have port score, output, SW=CW+$clog2(POS_PTS+NEG_PTS+1)+1, signed: final score.
REQ-014 SHALL have port key_err, output, 1: at least one key slot was not one-hot.

Function
REQ-015 SHALL implement states IDLE, SCAN, DONE; IDLE->SCAN on start, SCAN->DONE after question NQ-1, DONE->IDLE unconditionally.
REQ-016 SHALL latch key_in and resp_in on the clock edge that samples start high in IDLE; later input changes SHALL NOT affect the result.
REQ-017 SHALL ignore start while busy is high.
REQ-018 SHALL evaluate exactly one question per SCAN cycle, index 0 first, index NQ-1 last.
REQ-019 SHALL classify a response: all zero -> blank; more than one bit set -> invalid; one-hot equal to key -> correct; one-hot not equal to key -> wrong.
REQ-020 SHALL classify a question with a non-one-hot key slot as wrong (or invalid/blank per REQ-019), and SHALL set key_err sticky until the next start.
REQ-021 SHALL clear all counters and key_err on the start-accept edge.
REQ-022 SHALL assert busy from the cycle after start acceptance through the DONE cycle inclusive, i.e. NQ+1 cycles.
REQ-023 SHALL assert done for exactly one cycle (the DONE state), NQ+1 cycles after the start edge.
REQ-024 SHALL update score in the DONE cycle and hold score and all counters until the next start is accepted.
REQ-025 SHALL guarantee correct_cnt+wrong_cnt+blank_cnt+invalid_cnt == NQ at done.

Reset
REQ-026 SHALL, on reset_n low, asynchronously force state IDLE and busy, done, all counters, score and key_err to 0.
REQ-027 SHALL abandon any scan in progress on reset and SHALL NOT pulse done for it.

Configuration
REQ-028 SHALL, with OMR_NEG_MARK_EN defined, compute score = POS_PTS*correct_cnt - NEG_PTS*(wrong_cnt+invalid_cnt), allowed negative.
REQ-029 SHALL, without OMR_NEG_MARK_EN, compute score = POS_PTS*correct_cnt, never negative; NEG_PTS unused.

Structure
REQ-030 SHALL place the state enum, the answer-class enum (BLANK, CORRECT, WRONG, INVALID) and the width helper functions in package omr_pkg.
REQ-031 SHALL use one combinational sub-module omr_q_classify (NOPT-wide key and response in; class and key_bad out).

Verification (NQ=10, NOPT=4, POS_PTS=1, NEG_PTS=1)
REQ-032 SHALL verify: key=resp=0x1224121888, start -> done at cycle 11, correct=10, score=10, key_err=0.
REQ-033 SHALL verify: same key, resp with 2 wrong and 1 blank (0x0) and 1 double mark (0x3) -> correct=6, wrong=2, blank=1, invalid=1; score=3 with macro, 6 without.
REQ-034 SHALL verify: key slot 5 = 0x0 -> key_err=1 at done; next start with valid key clears it.
REQ-035 SHALL verify: start re-asserted at cycles 3..8 during scan -> ignored, exactly one done.
REQ-036 SHALL verify: reset_n low at cycle 5 of scan -> all outputs 0 immediately, no done; new start grades correctly.
REQ-037 SHALL verify: resp_in changed during SCAN -> result matches the sheet latched at start.
